bht_bank_ctrl: RTL and testbench

- Multi-bank branch history table with per-bank 2-bit saturating counters; each bank is a complete predictor state.
- A `bank_sel_i` input picks the active bank for lookups and updates. This lets the frontend swap predictor state (for example checkpoint or debug contexts) without corrupting the other banks.
- A background copy engine clones one bank into another, one entry per cycle, and keeps the two coherent against updates that arrive during the copy.
- Sits in the frontend next to the BTB; lookups are driven by the fetch vaddr and updates come from the resolved-branch bus.

---
 rtl/bht_bank_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_bht_bank_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_bank_ctrl.sv
// ---------------------------------------------------------------------------
// bht_bank_ctrl
//
// Multi-bank branch history table. Every bank is a complete predictor made of
// NR_ENTRIES entries, each holding a valid bit and a 2-bit saturating counter.
// One bank at a time is active for lookups and update capture. A background
// copy engine clones one bank into another, one entry per cycle, and keeps the
// two banks coherent with updates that land while the copy is running.
//
// Handshake / timing summary:
//   - Lookup is purely combinational from bank_sel_i and vpc_i. A write and a
//     lookup to the same entry in the same cycle return the old contents.
//   - An update strobe (update_valid_i=1, debug_mode_i=0) is registered
//     together with the bank selected in that cycle. The entry is written on
//     the following edge, into that registered bank.
//   - copy_req_i is a single-cycle request honoured only in IDLE. A valid
//     request starts the walk; an invalid one returns a one-cycle copy_err_o.
//     copy_busy_o is high from the accept edge until DONE is left, and
//     copy_done_o pulses for the single cycle spent in DONE.
//   - flush_i and rst_i win over everything else on the same edge.
//
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              invalidate every entry in every bank, abort a copy
//   debug_mode_i         suppress update capture
//   bank_sel_i           active bank for lookup and update capture
//   vpc_i                lookup PC
//   pred_valid_o         selected entry is valid
//   pred_taken_o         selected entry predicts taken
//   update_valid_i       resolved-branch update strobe
//   update_pc_i          PC of the resolved branch
//   update_taken_i       resolved outcome
//   copy_req_i           start a bank copy
//   copy_src_i           source bank
//   copy_dst_i           destination bank
//   copy_busy_o          copy engine is not IDLE
//   copy_done_o          one-cycle pulse on copy completion
//   copy_err_o           one-cycle pulse when a copy request is rejected
// ---------------------------------------------------------------------------
module bht_bank_ctrl #(
    parameter int NR_ENTRIES = 1024,
    parameter int N_BANKS    = 2,
    parameter int VLEN       = 64,
    parameter int INDEX_LSB  = 1,
    localparam int IDX_W     = $clog2(NR_ENTRIES),
    localparam int BANK_W    = (N_BANKS > 1) ? $clog2(N_BANKS) : 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              debug_mode_i,
    input  logic [BANK_W-1:0] bank_sel_i,
    input  logic [VLEN-1:0]   vpc_i,
    output logic              pred_valid_o,
    output logic              pred_taken_o,
    input  logic              update_valid_i,
    input  logic [VLEN-1:0]   update_pc_i,
    input  logic              update_taken_i,
    input  logic              copy_req_i,
    input  logic [BANK_W-1:0] copy_src_i,
    input  logic [BANK_W-1:0] copy_dst_i,
    output logic              copy_busy_o,
    output logic              copy_done_o,
    output logic              copy_err_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_COPY = 2'd1,
        ST_DONE = 2'd2
    } copy_state_e;

    // -----------------------------------------------------------------------
    // Storage: flops so that every bank can be cleared in one cycle.
    // -----------------------------------------------------------------------
    logic [NR_ENTRIES-1:0] r_valid [N_BANKS];
    logic [1:0]            r_cnt   [N_BANKS][NR_ENTRIES];

    // Registered update
    logic              r_upd_vld;
    logic [IDX_W-1:0]  r_upd_idx;
    logic              r_upd_taken;
    logic [BANK_W-1:0] r_upd_bank;

    // Copy engine
    copy_state_e       r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [BANK_W-1:0] r_src;
    logic [BANK_W-1:0] r_dst;
    logic              r_done;
    logic              r_err;

    // -----------------------------------------------------------------------
    // Lookup
    // -----------------------------------------------------------------------
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_lk_bank_ok;
    logic             w_lk_valid;

    assign w_lk_idx     = vpc_i[INDEX_LSB +: IDX_W];
    assign w_lk_bank_ok = int'(bank_sel_i) < N_BANKS;
    assign w_lk_valid   = w_lk_bank_ok & r_valid[bank_sel_i][w_lk_idx];

    assign pred_valid_o = w_lk_valid;
    assign pred_taken_o = w_lk_valid & r_cnt[bank_sel_i][w_lk_idx][1];

    // Only the index field of each PC is used; the remaining bits are folded
    // here so the intent of ignoring them is explicit.
    logic w_unused_pc_bits;
    assign w_unused_pc_bits = ^{vpc_i, update_pc_i};

    // -----------------------------------------------------------------------
    // Update value for the registered entry
    // -----------------------------------------------------------------------
    logic       w_upd_old_v;
    logic [1:0] w_upd_old_c;
    logic [1:0] w_upd_new_c;

    assign w_upd_old_v = r_valid[r_upd_bank][r_upd_idx];
    assign w_upd_old_c = r_cnt[r_upd_bank][r_upd_idx];

    always_comb begin
        w_upd_new_c = w_upd_old_c;
        if (!w_upd_old_v) begin
            // First sighting starts weakly biased toward the outcome.
            w_upd_new_c = r_upd_taken ? 2'b10 : 2'b01;
        end else if (r_upd_taken) begin
            w_upd_new_c = (w_upd_old_c == 2'b11) ? 2'b11 : w_upd_old_c + 2'd1;
        end else begin
            w_upd_new_c = (w_upd_old_c == 2'b00) ? 2'b00 : w_upd_old_c - 2'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Copy coherence decode
    // -----------------------------------------------------------------------
    logic w_copying;
    logic w_upd_to_dst;
    logic w_upd_mirror;
    logic w_upd_apply;
    logic w_req_ok;
    logic w_last;
    logic w_capture;

    assign w_copying    = (r_state == ST_COPY);
    // The destination is owned by the walk while copying.
    assign w_upd_to_dst = w_copying && (r_upd_bank == r_dst);
    // Source entries the walk has already passed (or is passing this cycle)
    // must also be written into the destination, otherwise the clone would
    // keep the stale value.
    assign w_upd_mirror = w_copying && (r_upd_bank == r_src) && (r_upd_idx <= r_ptr);
    assign w_upd_apply  = r_upd_vld && !w_upd_to_dst;

    assign w_req_ok  = (copy_src_i != copy_dst_i) &&
                       (int'(copy_src_i) < N_BANKS) &&
                       (int'(copy_dst_i) < N_BANKS);
    assign w_last    = (r_ptr == IDX_W'(NR_ENTRIES - 1));
    assign w_capture = update_valid_i && !debug_mode_i && w_lk_bank_ok;

    // -----------------------------------------------------------------------
    // Table storage writes
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_valid[b] <= '0;
                for (int e = 0; e < NR_ENTRIES; e++) begin
                    r_cnt[b][e] <= 2'b00;
                end
            end
        end else if (flush_i) begin
            for (int b = 0; b < N_BANKS; b++) begin
                r_valid[b] <= '0;
            end
        end else begin
            if (w_copying) begin
                r_valid[r_dst][r_ptr] <= r_valid[r_src][r_ptr];
                r_cnt[r_dst][r_ptr]   <= r_cnt[r_src][r_ptr];
            end
            // Issued after the walk write so that, when the update hits the
            // entry under the pointer, the destination takes the updated value.
            if (w_upd_apply) begin
                r_valid[r_upd_bank][r_upd_idx] <= 1'b1;
                r_cnt[r_upd_bank][r_upd_idx]   <= w_upd_new_c;
                if (w_upd_mirror) begin
                    r_valid[r_dst][r_upd_idx] <= 1'b1;
                    r_cnt[r_dst][r_upd_idx]   <= w_upd_new_c;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Update capture register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_upd_vld   <= 1'b0;
            r_upd_idx   <= '0;
            r_upd_taken <= 1'b0;
            r_upd_bank  <= '0;
        end else if (flush_i) begin
            r_upd_vld <= 1'b0;
        end else begin
            r_upd_vld <= w_capture;
            if (w_capture) begin
                r_upd_idx   <= update_pc_i[INDEX_LSB +: IDX_W];
                r_upd_taken <= update_taken_i;
                r_upd_bank  <= bank_sel_i;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Copy FSM with registered status outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_src   <= '0;
            r_dst   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (copy_req_i) begin
                        if (w_req_ok) begin
                            r_src   <= copy_src_i;
                            r_dst   <= copy_dst_i;
                            r_ptr   <= '0;
                            r_state <= ST_COPY;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_COPY: begin
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_ptr <= r_ptr + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign copy_busy_o = (r_state != ST_IDLE);
    assign copy_done_o = r_done;
    assign copy_err_o  = r_err;

endmodule

// File: tb/tb_bht_bank_ctrl.sv
module tb_bht_bank_ctrl;

  localparam int NE = 16;
  localparam int NB = 4;
  localparam int VL = 64;
  localparam int IL = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          dbg = 1'b0;
  logic [1:0]    bank_sel = '0;
  logic [VL-1:0] vpc = '0;
  logic          pred_valid;
  logic          pred_taken;
  logic          upd_valid = 1'b0;
  logic [VL-1:0] upd_pc = '0;
  logic          upd_taken = 1'b0;
  logic          copy_req = 1'b0;
  logic [1:0]    copy_src = '0;
  logic [1:0]    copy_dst = '0;
  logic          copy_busy;
  logic          copy_done;
  logic          copy_err;

  bht_bank_ctrl #(
    .NR_ENTRIES(NE),
    .N_BANKS(NB),
    .VLEN(VL),
    .INDEX_LSB(IL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .flush_i(flush),
    .debug_mode_i(dbg),
    .bank_sel_i(bank_sel),
    .vpc_i(vpc),
    .pred_valid_o(pred_valid),
    .pred_taken_o(pred_taken),
    .update_valid_i(upd_valid),
    .update_pc_i(upd_pc),
    .update_taken_i(upd_taken),
    .copy_req_i(copy_req),
    .copy_src_i(copy_src),
    .copy_dst_i(copy_dst),
    .copy_busy_o(copy_busy),
    .copy_done_o(copy_done),
    .copy_err_o(copy_err)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Table contents as plain integers; the copy engine as a phase plus a
  // position counter; the pending update as one record.
  bit mv [NB][NE];
  int mc [NB][NE];
  bit p_vld = 0;
  int p_bank = 0;
  int p_idx = 0;
  bit p_taken = 0;
  int phase = 0;   // 0 idle, 1 copying, 2 done
  int pos = 0;
  int csrc = 0;
  int cdst = 0;
  bit m_err = 0;

  function automatic int idx_of(input logic [VL-1:0] pc);
    return int'((pc >> IL) % 64'(NE));
  endfunction

  function automatic int next_cnt(input bit v, input int c, input bit t);
    if (!v) return t ? 2 : 1;
    if (t) return (c + 1 > 3) ? 3 : c + 1;
    return (c - 1 < 0) ? 0 : c - 1;
  endfunction

  task automatic model_edge();
    bit nv [NB][NE];
    int nc [NB][NE];
    int val;
    if (rst || flush) begin
      foreach (mv[b, i]) begin
        mv[b][i] = 0;
        if (rst) mc[b][i] = 0;
      end
      p_vld = 0;
      phase = 0;
      pos = 0;
      m_err = 0;
      return;
    end
    nv = mv;
    nc = mc;
    if (phase == 1) begin
      nv[cdst][pos] = mv[csrc][pos];
      nc[cdst][pos] = mc[csrc][pos];
    end
    if (p_vld && !(phase == 1 && p_bank == cdst)) begin
      val = next_cnt(mv[p_bank][p_idx], mc[p_bank][p_idx], p_taken);
      nv[p_bank][p_idx] = 1;
      nc[p_bank][p_idx] = val;
      if (phase == 1 && p_bank == csrc && p_idx <= pos) begin
        nv[cdst][p_idx] = 1;
        nc[cdst][p_idx] = val;
      end
    end
    mv = nv;
    mc = nc;
    m_err = 0;
    case (phase)
      0: if (copy_req) begin
           if (copy_src != copy_dst) begin
             csrc = int'(copy_src);
             cdst = int'(copy_dst);
             pos = 0;
             phase = 1;
           end else begin
             m_err = 1;
           end
         end
      1: if (pos == NE - 1) phase = 2; else pos++;
      default: phase = 0;
    endcase
    p_vld = upd_valid && !dbg;
    p_bank = int'(bank_sel);
    p_idx = idx_of(upd_pc);
    p_taken = upd_taken;
  endtask

  // Advance one clock: model steps on the same inputs the DUT samples.
  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    bit ev;
    bit et;
    ev = mv[int'(bank_sel)][idx_of(vpc)];
    et = ev && (mc[int'(bank_sel)][idx_of(vpc)] >= 2);
    chk({tag, ".valid"}, 32'(pred_valid), 32'(ev));
    chk({tag, ".taken"}, 32'(pred_taken), 32'(et));
    chk({tag, ".busy"}, 32'(copy_busy), 32'(phase != 0));
    chk({tag, ".done"}, 32'(copy_done), 32'(phase == 2));
    chk({tag, ".err"}, 32'(copy_err), 32'(m_err));
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; dbg = 0; upd_valid = 0; copy_req = 0;
  endtask

  // Look up every entry of every bank, one per cycle, against the model.
  task automatic scan_banks(input string tag);
    idle_inputs();
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NE; i++) begin
        bank_sel = 2'(b);
        vpc = 64'(i) << IL;
        #1;
        check_model(tag);
        cycle();
      end
    end
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    bit            dbg;
    bit            uv;
    logic [VL-1:0] upc;
    bit            ut;
    int            bsel;
    logic [VL-1:0] lpc;
    bit            ev;
    bit            et;
  } vec_t;

  vec_t vt [13];

  initial begin
    int busy_cnt;
    int done_cnt;
    int done_at;
    int err_cnt;
    int valid_cnt;

    // Counter walk on bank 0 idx 2, bank-capture check, aliasing, debug mode.
    vt[0]  = '{0, 1, 64'h4,  1, 0, 64'h4,  0, 0};
    vt[1]  = '{0, 1, 64'h4,  1, 0, 64'h4,  1, 1};  // 10
    vt[2]  = '{0, 1, 64'h4,  1, 0, 64'h4,  1, 1};  // 11
    vt[3]  = '{0, 1, 64'h4,  0, 0, 64'h4,  1, 1};  // 11 saturated
    vt[4]  = '{0, 1, 64'h4,  0, 0, 64'h4,  1, 1};  // 10
    vt[5]  = '{0, 0, 64'h0,  0, 0, 64'h4,  1, 0};  // 01
    vt[6]  = '{0, 0, 64'h0,  0, 1, 64'h4,  0, 0};  // other bank untouched
    vt[7]  = '{0, 1, 64'h8,  1, 2, 64'h8,  0, 0};  // captured into bank 2
    vt[8]  = '{0, 0, 64'h0,  0, 3, 64'h8,  0, 0};  // bank 3 stays empty
    vt[9]  = '{0, 0, 64'h0,  0, 2, 64'h8,  1, 1};  // landed in bank 2
    vt[10] = '{0, 0, 64'h0,  0, 0, 64'h24, 1, 0};  // aliases idx 2
    vt[11] = '{1, 1, 64'h10, 1, 0, 64'h10, 0, 0};  // debug suppresses
    vt[12] = '{0, 0, 64'h0,  0, 0, 64'h10, 0, 0};

    // ---- reset ----
    rst = 1;
    cycle();
    cycle();
    rst = 0;
    for (int b = 0; b < NB; b++) begin
      bank_sel = 2'(b);
      vpc = 64'h40;
      #1;
      chk("reset.valid", 32'(pred_valid), 0);
      chk("reset.taken", 32'(pred_taken), 0);
    end
    chk("reset.busy", 32'(copy_busy), 0);
    chk("reset.done", 32'(copy_done), 0);
    chk("reset.err", 32'(copy_err), 0);

    // ---- table ----
    for (int k = 0; k < 13; k++) begin
      dbg = vt[k].dbg;
      upd_valid = vt[k].uv;
      upd_pc = vt[k].upc;
      upd_taken = vt[k].ut;
      bank_sel = 2'(vt[k].bsel);
      vpc = vt[k].lpc;
      cycle();
      #1;
      chk($sformatf("vec%0d.valid", k), 32'(pred_valid), 32'(vt[k].ev));
      chk($sformatf("vec%0d.taken", k), 32'(pred_taken), 32'(vt[k].et));
    end
    idle_inputs();
    cycle();

    // ---- copy bank 0 -> bank 1 with traffic during the walk ----
    copy_req = 1; copy_src = 2'd0; copy_dst = 2'd1;
    cycle();  // accept edge
    copy_req = 0;
    busy_cnt = 0; done_cnt = 0; done_at = -1; err_cnt = 0;
    for (int c = 1; c <= 30; c++) begin
      upd_valid = 0;
      copy_req = 0;
      bank_sel = 2'($urandom_range(0, 3));
      vpc = {$urandom, $urandom};
      if (c == 3) begin upd_valid = 1; bank_sel = 0; upd_pc = 64'h0;  upd_taken = 1; end  // idx 0, already copied
      if (c == 5) begin upd_valid = 1; bank_sel = 1; upd_pc = 64'h6;  upd_taken = 1; end  // targets dst
      if (c == 6) begin upd_valid = 1; bank_sel = 0; upd_pc = 64'hC;  upd_taken = 1; end  // idx 6 == ptr
      if (c == 7) begin upd_valid = 1; bank_sel = 0; upd_pc = 64'h14; upd_taken = 0; end  // idx 10 ahead
      if (c == 8) begin copy_req = 1; copy_src = 2'd2; copy_dst = 2'd3; end
      #1;
      check_model("copy");
      if (copy_busy) busy_cnt++;
      if (copy_done) begin done_cnt++; done_at = c; end
      if (copy_err) err_cnt++;
      cycle();
    end
    chk("copy.busy_cycles", 32'(busy_cnt), 17);
    chk("copy.done_pulses", 32'(done_cnt), 1);
    chk("copy.done_cycle", 32'(done_at), 17);
    chk("copy.err_pulses", 32'(err_cnt), 0);
    idle_inputs();
    bank_sel = 1;
    vpc = 64'h0;  #1; chk("copy.b1i0.valid", 32'(pred_valid), 1); chk("copy.b1i0.taken", 32'(pred_taken), 1);
    vpc = 64'h6;  #1; chk("copy.b1i3.valid", 32'(pred_valid), 0);
    vpc = 64'hC;  #1; chk("copy.b1i6.valid", 32'(pred_valid), 1); chk("copy.b1i6.taken", 32'(pred_taken), 1);
    vpc = 64'h14; #1; chk("copy.b1i10.valid", 32'(pred_valid), 1); chk("copy.b1i10.taken", 32'(pred_taken), 0);
    vpc = 64'h4;  #1; chk("copy.b1i2.valid", 32'(pred_valid), 1); chk("copy.b1i2.taken", 32'(pred_taken), 0);
    cycle();
    scan_banks("copy_scan");

    // ---- rejected request ----
    copy_req = 1; copy_src = 2'd2; copy_dst = 2'd2;
    cycle();
    copy_req = 0;
    #1;
    chk("err.pulse", 32'(copy_err), 1);
    chk("err.busy", 32'(copy_busy), 0);
    check_model("err");
    cycle();
    #1;
    chk("err.clear", 32'(copy_err), 0);
    chk("err.still_idle", 32'(copy_busy), 0);

    // ---- flush in the middle of a copy, with a same-cycle update ----
    copy_req = 1; copy_src = 2'd0; copy_dst = 2'd2;
    cycle();
    copy_req = 0;
    for (int c = 1; c < 5; c++) begin
      #1;
      check_model("preflush");
      cycle();
    end
    flush = 1;
    upd_valid = 1; bank_sel = 3; upd_pc = 64'h1E; upd_taken = 1;
    cycle();
    idle_inputs();
    #1;
    chk("flush.busy", 32'(copy_busy), 0);
    chk("flush.done", 32'(copy_done), 0);
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      if (copy_done) done_cnt++;
      cycle();
    end
    chk("flush.no_done", 32'(done_cnt), 0);
    valid_cnt = 0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < NE; i++) begin
        bank_sel = 2'(b);
        vpc = 64'(i) << IL;
        #1;
        if (pred_valid) valid_cnt++;
        cycle();
      end
    end
    chk("flush.valid_entries", 32'(valid_cnt), 0);

    // ---- randomized traffic against the model ----
    for (int n = 0; n < 800; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      flush = ($urandom_range(0, 89) == 0);
      dbg = ($urandom_range(0, 9) == 0);
      upd_valid = 1'($urandom_range(0, 1));
      upd_pc = {$urandom, $urandom};
      upd_taken = 1'($urandom_range(0, 1));
      bank_sel = 2'($urandom_range(0, 3));
      vpc = {$urandom, $urandom};
      copy_req = ($urandom_range(0, 24) == 0);
      copy_src = 2'($urandom_range(0, 3));
      copy_dst = 2'($urandom_range(0, 3));
      #1;
      check_model("rand");
      cycle();
    end
    idle_inputs();
    for (int c = 0; c < 20; c++) cycle();
    scan_banks("final_scan");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
